dac_sample_serializer: RTL and testbench



---
 rtl/sine_gen_pkg.sv | 8 +
 rtl/dac_sample_serializer_if.sv | 19 +
 rtl/dac_sample_serializer_sclk_tick_gen.sv | 18 +
 rtl/dac_sample_serializer.sv | 68 ++++++
 tb/tb_dac_sample_serializer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_gen_pkg.sv
// sine_gen_pkg: shared constants and types for the sine generator sample path
package sine_gen_pkg;
  localparam int DATA_W_DEF = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  typedef logic [DATA_W_DEF-1:0] sample_t;
endpackage

// File: rtl/dac_sample_serializer_if.sv
// dac_sample_serializer_if: sample handshake plus 3-wire DAC pins and status
interface dac_sample_serializer_if #(parameter int DATA_W = sine_gen_pkg::DATA_W_DEF);
  logic [DATA_W-1:0] sample_in;
  logic sample_valid;
  logic sample_ready;
  logic dac_sclk;
  logic dac_din;
  logic dac_cs_n;
  logic busy;
  logic done;
  modport master (
    output sample_in, sample_valid,
    input  sample_ready, dac_sclk, dac_din, dac_cs_n, busy, done
  );
  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, dac_sclk, dac_din, dac_cs_n, busy, done
  );
endinterface

// File: rtl/dac_sample_serializer_sclk_tick_gen.sv
// sclk_tick_gen: divider that ticks once every CLK_DIV enabled cycles
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  assign tick = en && div == DW'(CLK_DIV - 1);
  // count enabled cycles, wrapping to zero on the terminal count
  always_ff @(posedge clk)
    if (rst || clr) div <= '0;
    else if (en) div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/dac_sample_serializer.sv
// dac_sample_serializer: shifts handshaken samples MSB-first to a 3-wire serial DAC
module dac_sample_serializer
  import sine_gen_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input logic clk,
  input logic rst,
  dac_sample_serializer_if.slave bus
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  logic [1:0] state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic sclk, done, tick, gap_end, ready, take;
  // the last gap cycle already offers ready so back-to-back frames keep the gap at CS_GAP
  assign gap_end = state == S_GAP && gcnt == GW'(CS_GAP - 1);
  assign ready = state == S_IDLE || gap_end;
  assign take = bus.sample_valid && ready;
  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(take),
    .en(state == S_SHIFT),
    .tick(tick)
  );
  // frame FSM: capture, toggle sclk on ticks, shift on falling edges, then hold cs_n high
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      sclk  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take) begin
        state <= S_SHIFT;
        shreg <= bus.sample_in;
        bcnt  <= BW'(DATA_W - 1);
        sclk  <= 1'b0;
      end else if (state == S_SHIFT && tick) begin
        sclk <= ~sclk;
        if (sclk && bcnt == '0) begin
          state <= S_GAP;
          gcnt  <= '0;
          done  <= 1'b1;
        end else if (sclk) begin
          shreg <= shreg << 1;
          bcnt  <= bcnt - 1'b1;
        end
      end else if (state == S_GAP) begin
        if (gap_end) state <= S_IDLE;
        else gcnt <= gcnt + 1'b1;
      end
    end
  assign bus.sample_ready = ready;
  assign bus.busy = state != S_IDLE;
  assign bus.dac_cs_n = state != S_SHIFT;
  assign bus.dac_sclk = sclk;
  assign bus.dac_din = state == S_SHIFT && shreg[DATA_W-1];
  assign bus.done = done;
endmodule

// File: tb/tb_dac_sample_serializer.sv
// tb_dac_sample_serializer: directed checks of framing, pacing, reset and capture
module tb_dac_sample_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dac_sample_serializer_if i0 ();
  dac_sample_serializer_if i1 ();
  dac_sample_serializer u0 (.clk(clk), .rst(rst), .bus(i0));
  dac_sample_serializer #(.CLK_DIV(1), .CS_GAP(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  logic cs[2], sc[2], dn[2], dd[2];
  assign cs[0] = i0.dac_cs_n;
  assign sc[0] = i0.dac_sclk;
  assign dn[0] = i0.dac_din;
  assign dd[0] = i0.done;
  assign cs[1] = i1.dac_cs_n;
  assign sc[1] = i1.dac_sclk;
  assign dn[1] = i1.dac_din;
  assign dd[1] = i1.done;
  logic pcs[2] = '{1'b1, 1'b1};
  logic psc[2] = '{1'b0, 1'b0};
  logic pdn[2] = '{1'b0, 1'b0};
  logic [15:0] bits[2];
  int start[2], low[2], ntog[2], dhi[2], dcyc[2], ndone[2], frames[2], din_bad[2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; low[i] = 0; ntog[i] = 0; dhi[i] = 0; dcyc[i] = 0;
      ndone[i] = 0; frames[i] = 0; din_bad[i] = 0; bits[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!cs[i] && pcs[i]) begin start[i] = cyc; bits[i] = '0; ntog[i] = 0; low[i] = 0; dhi[i] = 0; end
        if (!cs[i]) begin low[i]++; if (dn[i]) dhi[i]++; end
        if (!cs[i] && !pcs[i] && dn[i] != pdn[i] && !(psc[i] && !sc[i])) din_bad[i]++;
        if (sc[i] != psc[i]) begin ntog[i]++; if (sc[i]) bits[i] = {bits[i][14:0], dn[i]}; end
        if (dd[i]) begin dcyc[i] = cyc; ndone[i]++; end
        if (cs[i] && !pcs[i]) frames[i]++;
        pcs[i] = cs[i]; psc[i] = sc[i]; pdn[i] = dn[i];
      end
    end
  end
  task automatic nclk;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_frame(input int i, input int lim);
    int f;
    f = frames[i];
    for (int k = 0; k < lim && frames[i] == f; k++) nclk();
    checks++;
    if (frames[i] == f) begin fails++; $display("FAIL frame_timeout dut%0d: no frame end within %0d cycles", i, lim); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    i0.sample_in = 16'hFFFF; i0.sample_valid = 1'b1;
    i1.sample_in = 16'h0000; i1.sample_valid = 1'b0;
    repeat (3) nclk();
    checks++;
    if ({i0.sample_ready, i0.busy, i0.dac_cs_n, i0.dac_sclk, i0.dac_din, i0.done} !== 6'b101000) begin
      fails++; $display("FAIL reset_outputs: got %b want 101000", {i0.sample_ready, i0.busy, i0.dac_cs_n, i0.dac_sclk, i0.dac_din, i0.done});
    end
    checks++;
    if ({i1.sample_ready, i1.busy, i1.dac_cs_n, i1.dac_sclk, i1.dac_din, i1.done} !== 6'b101000) begin
      fails++; $display("FAIL reset_outputs_fast: got %b want 101000", {i1.sample_ready, i1.busy, i1.dac_cs_n, i1.dac_sclk, i1.dac_din, i1.done});
    end
    i0.sample_valid = 1'b0;
    rst = 1'b0;
    nclk();
  endtask
  task automatic test_single;
    int t0, nd;
    nd = ndone[0];
    i0.sample_in = 16'hA5C3; i0.sample_valid = 1'b1; t0 = cyc + 1;
    nclk();
    i0.sample_valid = 1'b0;
    checks++;
    if (start[0] !== t0) begin fails++; $display("FAIL single_start: got %0d want %0d", start[0], t0); end
    checks++;
    if ({i0.dac_cs_n, i0.dac_din, i0.dac_sclk, i0.sample_ready} !== 4'b0100) begin
      fails++; $display("FAIL single_first_cycle cs/din/sclk/ready: got %b want 0100", {i0.dac_cs_n, i0.dac_din, i0.dac_sclk, i0.sample_ready});
    end
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'hA5C3) begin fails++; $display("FAIL single_bits: got %h want a5c3", bits[0]); end
    checks++;
    if (low[0] !== 128) begin fails++; $display("FAIL single_cs_low: got %0d want 128", low[0]); end
    checks++;
    if (ntog[0] !== 32) begin fails++; $display("FAIL single_toggles: got %0d want 32", ntog[0]); end
    checks++;
    if (dcyc[0] !== t0 + 128 || ndone[0] !== nd + 1) begin
      fails++; $display("FAIL single_done: got cycle %0d count %0d want %0d count %0d", dcyc[0], ndone[0], t0 + 128, nd + 1);
    end
    checks++;
    if (cyc !== t0 + 128 || i0.sample_ready !== 1'b0) begin
      fails++; $display("FAIL single_frame_end: got cycle %0d ready %b want %0d ready 0", cyc, i0.sample_ready, t0 + 128);
    end
    nclk();
    checks++;
    if ({i0.done, i0.busy, i0.dac_cs_n} !== 3'b011) begin fails++; $display("FAIL single_gap: got done/busy/cs %b want 011", {i0.done, i0.busy, i0.dac_cs_n}); end
    nclk();
    checks++;
    if ({i0.sample_ready, i0.busy} !== 2'b10) begin fails++; $display("FAIL single_idle: got ready/busy %b want 10", {i0.sample_ready, i0.busy}); end
  endtask
  task automatic test_back_to_back;
    int t0, e1;
    logic [15:0] b1;
    i0.sample_in = 16'hFFFF; i0.sample_valid = 1'b1; t0 = cyc + 1;
    wait_frame(0, 200);
    b1 = bits[0]; e1 = cyc;
    i0.sample_in = 16'h0001;
    nclk();
    nclk();
    i0.sample_valid = 1'b0;
    checks++;
    if (b1 !== 16'hFFFF) begin fails++; $display("FAIL b2b_first_bits: got %h want ffff", b1); end
    checks++;
    if (e1 !== t0 + 128) begin fails++; $display("FAIL b2b_first_end: got %0d want %0d", e1, t0 + 128); end
    checks++;
    if (start[0] !== t0 + 130) begin fails++; $display("FAIL b2b_second_start: got %0d want %0d", start[0], t0 + 130); end
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h0001 || low[0] !== 128) begin
      fails++; $display("FAIL b2b_second_frame: got bits %h low %0d want 0001 low 128", bits[0], low[0]);
    end
    nclk();
    nclk();
  endtask
  task automatic test_ignore;
    int t0, t1;
    i0.sample_in = 16'h5A5A; i0.sample_valid = 1'b1; t0 = cyc + 1;
    nclk();
    i0.sample_valid = 1'b0;
    while (cyc < t0 + 19) nclk();
    i0.sample_in = 16'h1234; i0.sample_valid = 1'b1;
    checks++;
    if (i0.sample_ready !== 1'b0) begin fails++; $display("FAIL ignore_ready: got %b want 0", i0.sample_ready); end
    nclk();
    i0.sample_valid = 1'b0;
    checks++;
    if (start[0] !== t0 || i0.busy !== 1'b1) begin fails++; $display("FAIL ignore_no_restart: got start %0d busy %b want %0d busy 1", start[0], i0.busy, t0); end
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h5A5A) begin fails++; $display("FAIL ignore_bits: got %h want 5a5a", bits[0]); end
    nclk();
    nclk();
    i0.sample_in = 16'h1234; i0.sample_valid = 1'b1; t1 = cyc + 1;
    nclk();
    i0.sample_valid = 1'b0;
    checks++;
    if (start[0] !== t1 || t1 < t0 + 130) begin fails++; $display("FAIL ignore_late_accept: got %0d want %0d", start[0], t1); end
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h1234) begin fails++; $display("FAIL ignore_late_bits: got %h want 1234", bits[0]); end
    nclk();
    nclk();
  endtask
  task automatic test_reset_mid;
    int t0, nd;
    i0.sample_in = 16'hC3A5; i0.sample_valid = 1'b1; t0 = cyc + 1;
    nclk();
    i0.sample_valid = 1'b0;
    while (cyc < t0 + 43) nclk();
    checks++;
    if (i0.dac_sclk !== 1'b0) begin fails++; $display("FAIL rstmid_pre_sclk: got %b want 0", i0.dac_sclk); end
    nd = ndone[0];
    rst = 1'b1;
    nclk();
    checks++;
    if ({i0.sample_ready, i0.busy, i0.dac_cs_n, i0.dac_sclk, i0.dac_din, i0.done} !== 6'b101000) begin
      fails++; $display("FAIL rstmid_outputs: got %b want 101000", {i0.sample_ready, i0.busy, i0.dac_cs_n, i0.dac_sclk, i0.dac_din, i0.done});
    end
    rst = 1'b0;
    repeat (5) nclk();
    checks++;
    if (ndone[0] !== nd || i0.dac_cs_n !== 1'b1) begin fails++; $display("FAIL rstmid_no_done: got done count %0d cs %b want %0d cs 1", ndone[0], i0.dac_cs_n, nd); end
    i0.sample_in = 16'h0F0F; i0.sample_valid = 1'b1; t0 = cyc + 1;
    nclk();
    i0.sample_valid = 1'b0;
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h0F0F || low[0] !== 128 || ntog[0] !== 32 || dcyc[0] !== t0 + 128) begin
      fails++; $display("FAIL rstmid_next_frame: got bits %h low %0d tog %0d done %0d want 0f0f 128 32 %0d", bits[0], low[0], ntog[0], dcyc[0], t0 + 128);
    end
    nclk();
    nclk();
  endtask
  task automatic test_boundary;
    i0.sample_in = 16'h8000; i0.sample_valid = 1'b1;
    nclk();
    i0.sample_valid = 1'b0;
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h8000 || ntog[0] !== 32 || dhi[0] !== 8) begin
      fails++; $display("FAIL boundary_8000: got bits %h tog %0d din_high %0d want 8000 32 8", bits[0], ntog[0], dhi[0]);
    end
    nclk();
    nclk();
    i0.sample_in = 16'h0000; i0.sample_valid = 1'b1;
    nclk();
    i0.sample_valid = 1'b0;
    wait_frame(0, 200);
    checks++;
    if (bits[0] !== 16'h0000 || ntog[0] !== 32 || dhi[0] !== 0) begin
      fails++; $display("FAIL boundary_0000: got bits %h tog %0d din_high %0d want 0000 32 0", bits[0], ntog[0], dhi[0]);
    end
    nclk();
    nclk();
  endtask
  task automatic test_fast;
    int t0, f;
    i1.sample_in = 16'h3C3C; i1.sample_valid = 1'b1; t0 = cyc + 1;
    f = frames[1];
    for (int k = 0; k < 80 && frames[1] == f; k++) begin
      nclk();
      if (frames[1] == f) i1.sample_in = 16'($urandom);
    end
    checks++;
    if (frames[1] == f) begin fails++; $display("FAIL fast_timeout: no frame end within 80 cycles"); end
    checks++;
    if (bits[1] !== 16'h3C3C || low[1] !== 32 || ntog[1] !== 32 || dcyc[1] !== t0 + 32) begin
      fails++; $display("FAIL fast_frame: got bits %h low %0d tog %0d done %0d want 3c3c 32 32 %0d", bits[1], low[1], ntog[1], dcyc[1], t0 + 32);
    end
    i1.sample_in = 16'h0BAD;
    nclk();
    i1.sample_valid = 1'b0;
    checks++;
    if (start[1] !== t0 + 33) begin fails++; $display("FAIL fast_period: got %0d want %0d", start[1], t0 + 33); end
    wait_frame(1, 80);
    checks++;
    if (bits[1] !== 16'h0BAD) begin fails++; $display("FAIL fast_second_bits: got %h want 0bad", bits[1]); end
    nclk();
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_boundary();
    test_fast();
    checks++;
    if (din_bad[0] !== 0 || din_bad[1] !== 0) begin
      fails++; $display("FAIL din_stability: got %0d/%0d changes off falling edges want 0/0", din_bad[0], din_bad[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
